test_sequencer: RTL and testbench

Synthesizable self-check harness that runs NUM_TESTS generated test modules one after another over their req/busy/return handshake. Generates a reset pulse for the modules under test, applies a start delay and a busy-guard window, and enforces a per-test timeout. Records a pass/fail bit and a timeout bit per test, and raises an aggregate pass/done result. Sits at the top of on-chip or simulation regression wrappers in place of per-test ad-hoc benches.

---
 rtl/test_sequencer.sv | 168 ++++++++++++++++
 tb/tb_test_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// Sequences NUM_TESTS modules under test over a req/busy/return handshake,
// with a reset pulse, start delay, busy-guard window and per-test timeout.
module test_sequencer #(
    parameter int NUM_TESTS   = 4,
    parameter int START_DELAY = 100,
    parameter int RST_LEN     = 6,
    parameter int BUSY_GUARD  = 5,
    parameter int TIMEOUT     = 100000,
    parameter int CNT_W       = 32,
    parameter int IDX_W       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 test_reset,
    output logic [NUM_TESTS-1:0] test_req,
    input  logic [NUM_TESTS-1:0] test_busy,
    input  logic [NUM_TESTS-1:0] test_return,
    output logic [IDX_W-1:0]     cur_idx,
    output logic [NUM_TESTS-1:0] result,
    output logic [NUM_TESTS-1:0] timeout_flag,
    output logic [IDX_W:0]       pass_count,
    output logic                 done,
    output logic                 pass
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_GUARD,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(START_DELAY);
    localparam logic [CNT_W-1:0] RST_END   = CNT_W'(RST_LEN);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(BUSY_GUARD - 1);
    localparam logic [CNT_W-1:0] TMO_END   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TESTS - 1);
    localparam logic [IDX_W:0]   ALL_PASS  = (IDX_W + 1)'(NUM_TESTS);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 test_reset_nxt;
    logic [NUM_TESTS-1:0] req_nxt;
    logic [IDX_W-1:0]     idx_nxt, idx_inc;
    logic [NUM_TESTS-1:0] result_nxt, tmo_nxt;
    logic [IDX_W:0]       pcnt_nxt;
    logic                 done_nxt, pass_nxt;
    logic                 cur_busy, cur_ret;

    assign cur_busy = test_busy[cur_idx];
    assign cur_ret  = test_return[cur_idx];
    assign idx_inc  = cur_idx + 1'b1;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        test_reset_nxt = 1'b0;
        req_nxt        = test_req;
        idx_nxt        = cur_idx;
        result_nxt     = result;
        tmo_nxt        = timeout_flag;
        pcnt_nxt       = pass_count;
        done_nxt       = done;
        pass_nxt       = pass;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_DELAY;
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                    req_nxt    = '0;
                    result_nxt = '0;
                    tmo_nxt    = '0;
                    pcnt_nxt   = '0;
                    done_nxt   = 1'b0;
                    pass_nxt   = 1'b0;
                end
            end
            S_DELAY: begin
                // Reset pulse covers the first RST_LEN delay cycles only.
                test_reset_nxt = (cnt < RST_END);
                if (cnt == DELAY_END) begin
                    req_nxt          = '0;
                    req_nxt[cur_idx] = 1'b1;
                    cnt_nxt          = '0;
                    state_nxt        = S_GUARD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GUARD: begin
                if (cnt == GUARD_END) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                // Completion is checked before timeout so it wins on a tie.
                if (!cur_busy) begin
                    result_nxt[cur_idx] = cur_ret;
                    pcnt_nxt            = pass_count + {{IDX_W{1'b0}}, cur_ret};
                    req_nxt             = '0;
                    state_nxt           = S_GAP;
                end else if (cnt == TMO_END) begin
                    tmo_nxt[cur_idx] = 1'b1;
                    req_nxt          = '0;
                    state_nxt        = S_GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (cur_idx == LAST_IDX) begin
                    done_nxt  = 1'b1;
                    pass_nxt  = (pass_count == ALL_PASS);
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt          = idx_inc;
                    req_nxt          = '0;
                    req_nxt[idx_inc] = 1'b1;
                    cnt_nxt          = '0;
                    state_nxt        = S_GUARD;
                end
            end
            S_DONE: begin
                if (!start) begin
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            test_reset   <= 1'b0;
            test_req     <= '0;
            cur_idx      <= '0;
            result       <= '0;
            timeout_flag <= '0;
            pass_count   <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            test_reset   <= test_reset_nxt;
            test_req     <= req_nxt;
            cur_idx      <= idx_nxt;
            result       <= result_nxt;
            timeout_flag <= tmo_nxt;
            pass_count   <= pcnt_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: timeline model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_test_sequencer;

    localparam int N     = 3;
    localparam int SD    = 10;
    localparam int RL    = 4;
    localparam int BG    = 5;
    localparam int TO    = 50;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             test_reset;
    logic [N-1:0]     test_req;
    logic [N-1:0]     test_busy = '0;
    logic [N-1:0]     test_return = '0;
    logic [IDX_W-1:0] cur_idx;
    logic [N-1:0]     result;
    logic [N-1:0]     timeout_flag;
    logic [IDX_W:0]   pass_count;
    logic             done;
    logic             pass;

    test_sequencer #(
        .NUM_TESTS  (N),
        .START_DELAY(SD),
        .RST_LEN    (RL),
        .BUSY_GUARD (BG),
        .TIMEOUT    (TO),
        .CNT_W      (16),
        .IDX_W      (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .test_reset  (test_reset),
        .test_req    (test_req),
        .test_busy   (test_busy),
        .test_return (test_return),
        .cur_idx     (cur_idx),
        .result      (result),
        .timeout_flag(timeout_flag),
        .pass_count  (pass_count),
        .done        (done),
        .pass        (pass)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Responder profile per channel: busy drops drop[t] cycles after req rises
    int unsigned drop[N];
    bit          stuck[N];
    bit          rv[N];
    int unsigned age[N];

    initial begin
        for (int unsigned t = 0; t < N; t++) age[t] = 0;
        forever begin
            @(negedge clk);
            for (int unsigned t = 0; t < N; t++) begin
                if (test_req[t]) age[t] = age[t] + 1;
                else age[t] = 0;
                test_busy[t]   = test_req[t] && (stuck[t] || age[t] < drop[t]);
                test_return[t] = rv[t];
            end
        end
    end

    // Request rise/fall edge numbers
    int          rise_c[N];
    int          fall_c[N];
    logic [N-1:0] prev_req = '0;
    always @(negedge clk) begin
        for (int unsigned t = 0; t < N; t++) begin
            if (test_req[t] && !prev_req[t]) rise_c[t] = cyc;
            if (!test_req[t] && prev_req[t]) fall_c[t] = cyc;
        end
        prev_req = test_req;
    end

    // Timeline model
    logic             m_reset;
    logic [N-1:0]     m_req;
    logic [IDX_W-1:0] m_idx;
    logic [N-1:0]     m_res;
    logic [N-1:0]     m_tmo;
    int               m_pc;
    logic             m_done;
    logic             m_pass;

    task automatic m_zero();
        m_reset = 1'b0; m_req = '0; m_idx = '0; m_res = '0; m_tmo = '0;
        m_pc = 0; m_done = 1'b0; m_pass = 1'b0;
    endtask

    task automatic m_edge(output bit ab);
        @(posedge clk or negedge reset);
        ab = !reset;
        if (ab) m_zero();
    endtask

    initial begin : model_proc
        bit ab;
        m_zero();
        forever begin
            if (!reset) @(posedge reset);
            ab = 1'b0;
            forever begin
                m_edge(ab);
                if (ab || start) break;
            end
            if (ab) continue;
            m_res = '0; m_tmo = '0; m_pc = 0; m_done = 1'b0; m_pass = 1'b0;
            m_idx = '0; m_req = '0;
            for (int unsigned j = 1; j <= SD + 1; j++) begin
                m_edge(ab);
                if (ab) break;
                m_reset = (j <= RL);
                if (j == SD + 1) m_req[0] = 1'b1;
            end
            if (ab) continue;
            for (int unsigned t = 0; t < N; t++) begin
                for (int unsigned g = 0; g < BG; g++) begin
                    m_edge(ab);
                    if (ab) break;
                end
                if (ab) break;
                for (int unsigned w = 1; w <= TO; w++) begin
                    m_edge(ab);
                    if (ab) break;
                    if (!test_busy[t]) begin
                        m_res[t] = test_return[t];
                        m_pc     = m_pc + int'(test_return[t]);
                        m_req    = '0;
                        break;
                    end
                    if (w == TO) begin
                        m_tmo[t] = 1'b1;
                        m_req    = '0;
                    end
                end
                if (ab) break;
                m_edge(ab);
                if (ab) break;
                if (t == N - 1) begin
                    m_done = 1'b1;
                    m_pass = (m_pc == N);
                end else begin
                    m_idx          = IDX_W'(t + 1);
                    m_req          = '0;
                    m_req[t + 1]   = 1'b1;
                end
            end
            if (ab) continue;
            forever begin
                m_edge(ab);
                if (ab) break;
                if (!start) begin
                    m_done = 1'b0;
                    m_pass = 1'b0;
                    break;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("test_reset", test_reset, m_reset);
        chk("test_req", test_req, m_req);
        chk("cur_idx", cur_idx, m_idx);
        chk("result", result, m_res);
        chk("timeout_flag", timeout_flag, m_tmo);
        chk("pass_count", pass_count, m_pc);
        chk("done", done, m_done);
        chk("pass", pass, m_pass);
        chk("req_onehot", ($countones(test_req) <= 1), 1);
        chk("req_during_reset", (test_req != '0) && test_reset, 0);
    end

    int k;

    task automatic set_profile(input int unsigned d0, input int unsigned d1, input int unsigned d2,
                               input bit r0, input bit r1, input bit r2,
                               input bit s0, input bit s1, input bit s2);
        drop[0] = d0; drop[1] = d1; drop[2] = d2;
        rv[0] = r0; rv[1] = r1; rv[2] = r2;
        stuck[0] = s0; stuck[1] = s1; stuck[2] = s2;
    endtask

    // Called at a negedge; pins the reset pulse and first request edge when asked
    task automatic start_run(input bit pin);
        start = 1'b1;
        k = cyc + 1;
        if (pin) begin
            for (int unsigned m = 0; m <= 11; m++) begin
                @(negedge clk);
                chk("pin_test_reset", test_reset, (m >= 1 && m <= RL) ? 1 : 0);
                chk("pin_req", test_req, (m == SD + 1) ? 1 : 0);
            end
        end
        for (int unsigned i = 0; i < 3000 && !done; i++) @(negedge clk);
        chk("done_reached", done, 1);
    endtask

    task automatic finish_run();
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_dropped", done, 0);
        chk("pass_dropped", pass, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_profile(20, 20, 20, 1, 1, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_req", test_req, 0);
        chk("rst_result", result, 0);
        chk("rst_done", done, 0);
        chk("rst_test_reset", test_reset, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All pass
        start_run(1);
        chk("allpass_result", result, 3'b111);
        chk("allpass_count", pass_count, 3);
        chk("allpass_pass", pass, 1);
        chk("allpass_tmo", timeout_flag, 0);
        chk("req0_rise", rise_c[0] - k, SD + 1);
        chk("lat0", fall_c[0] - rise_c[0], 20);
        chk("gap01", rise_c[1] - fall_c[0], 1);
        chk("gap12", rise_c[2] - fall_c[1], 1);
        repeat (3) @(negedge clk);
        chk("done_held", done, 1);
        finish_run();
        chk("result_held", result, 3'b111);

        // Mixed
        set_profile(20, 20, 20, 1, 0, 1, 0, 0, 0);
        start_run(0);
        chk("mixed_result", result, 3'b101);
        chk("mixed_tmo", timeout_flag, 0);
        chk("mixed_count", pass_count, 2);
        chk("mixed_pass", pass, 0);
        finish_run();

        // Timeout
        set_profile(20, 20, 20, 1, 1, 1, 0, 0, 1);
        start_run(0);
        chk("tmo_flag", timeout_flag, 3'b100);
        chk("tmo_result", result, 3'b011);
        chk("tmo_pass", pass, 0);
        chk("tmo_len", fall_c[2] - rise_c[2], BG + TO);
        finish_run();

        // Guard: busy never raised
        set_profile(0, 0, 0, 1, 1, 1, 0, 0, 0);
        start_run(0);
        chk("guard_lat", fall_c[0] - rise_c[0], BG + 1);
        chk("guard_result", result, 3'b111);
        finish_run();

        // Completion and timeout on the same edge
        set_profile(BG + TO, 20, 20, 1, 1, 1, 0, 0, 0);
        start_run(0);
        chk("simul_lat", fall_c[0] - rise_c[0], BG + TO);
        chk("simul_result", result, 3'b111);
        chk("simul_tmo", timeout_flag, 0);
        finish_run();

        // Reset mid-run during test1 WAIT
        set_profile(20, 20, 20, 1, 1, 1, 0, 0, 0);
        start = 1'b1;
        for (int unsigned i = 0; i < 500 && !test_req[1]; i++) @(negedge clk);
        chk("req1_seen", test_req[1], 1);
        repeat (8) @(negedge clk);
        chk("pre_rst_result", result, 3'b001);
        #2 reset = 1'b0;
        start = 1'b0;
        #1;
        chk("async_req", test_req, 0);
        chk("async_result", result, 0);
        chk("async_idx", cur_idx, 0);
        chk("async_count", pass_count, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_run(1);
        chk("restart_result", result, 3'b111);
        chk("restart_req0", rise_c[0] - k, SD + 1);
        finish_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
